// File: rtl/max6675_pkg.sv
// Shared types and frame-layout constants for the MAX6675 SPI reader.
// The frame is 16 bits, D15 first: dummy, 12-bit temperature, open flag, device ID, tri-state.
package max6675_pkg;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int DUMMY_BIT  = 15;
   localparam int TEMP_MSB   = 14;
   localparam int TEMP_LSB   = 3;
   localparam int OPEN_BIT   = 2;
   localparam int ID_BIT     = 1;

   // A healthy device always returns zero in the dummy and ID positions.
   function automatic logic frame_fault(input logic [FRAME_BITS-1:0] word);
      return word[DUMMY_BIT] | word[ID_BIT];
   endfunction

endpackage

// File: rtl/max6675_sync2.sv
// Two-flop synchronizer bringing the asynchronous MAX6675 SO line into the clk domain.
module max6675_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   // NOTE: sequential state uses non-blocking assignments so both flops sample the old values on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

// File: rtl/max6675_spi_reader.sv
// Autonomous MAX6675 reader: waits one conversion period, clocks out one 16-bit frame, repeats.
// The last complete frame is held on temp_word with its status flags until the next one lands.
module max6675_spi_reader
   import max6675_pkg::*;
#(
   parameter int CLK_DIV     = 13,
   parameter int CONV_CYCLES = 12_500_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        so,
   output logic        cs_n,
   output logic        sck,
   output logic [15:0] temp_word,
   output logic        valid,
   output logic        open_tc,
   output logic        frame_err,
   output logic        busy
);

   localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WW = $clog2(CONV_CYCLES + 1);

   localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
   localparam logic [WW-1:0] WAIT_LOAD = WW'(CONV_CYCLES);
   localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
   localparam logic [4:0]    LAST_BIT  = 5'(FRAME_BITS - 1);

   if (CLK_DIV < 3) begin : g_clk_div_check
      $error("max6675_spi_reader: CLK_DIV must be at least 3");
   end

   state_t                r_state;
   state_t                w_state_nxt;
   logic [HW-1:0]         r_half_cnt;
   logic [HW-1:0]         w_half_nxt;
   logic [4:0]            r_bit_cnt;
   logic [4:0]            w_bit_nxt;
   logic [WW-1:0]         r_wait_cnt;
   logic [WW-1:0]         w_wait_nxt;
   logic                  r_sck;
   logic                  w_sck_nxt;
   logic                  r_cs_n;
   logic                  w_cs_n_nxt;
   logic [FRAME_BITS-1:0] r_shift;
   logic [FRAME_BITS-1:0] w_shift_nxt;
   logic                  w_frame_end;
   logic                  w_half_last;
   logic                  w_wait_expired;
   logic                  w_so_sync;

   logic [15:0]           r_temp_word;
   logic                  r_valid;
   logic                  r_open_tc;
   logic                  r_frame_err;

   max6675_sync2 u_so_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (so),
      .q       (w_so_sync)
   );

   assign w_half_last = (r_half_cnt == HALF_LAST);
   // Counter value 1 is the last WAIT cycle; 0 means the period expired while enable was low.
   assign w_wait_expired = (r_wait_cnt <= WAIT_ONE);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_half_nxt  = r_half_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_wait_nxt  = r_wait_cnt;
      w_sck_nxt   = r_sck;
      w_cs_n_nxt  = r_cs_n;
      w_shift_nxt = r_shift;
      w_frame_end = 1'b0;

      case (r_state)
         WAIT: begin
            w_cs_n_nxt = 1'b1;
            w_sck_nxt  = 1'b0;
            if (r_wait_cnt != '0) begin
               w_wait_nxt = r_wait_cnt - 1'b1;
            end
            if (w_wait_expired && enable) begin
               w_state_nxt = SETUP;
               w_cs_n_nxt  = 1'b0;
               w_half_nxt  = '0;
               w_bit_nxt   = '0;
            end
         end

         SETUP: begin
            if (w_half_last) begin
               w_state_nxt = SHIFT;
               w_half_nxt  = '0;
               w_sck_nxt   = 1'b1;
            end else begin
               w_half_nxt = r_half_cnt + 1'b1;
            end
         end

         SHIFT: begin
            if (!w_half_last) begin
               w_half_nxt = r_half_cnt + 1'b1;
            end else begin
               w_half_nxt = '0;
               if (r_sck) begin
                  // Last high cycle: SO changed a full low phase ago and has cleared the synchronizer.
                  w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_so_sync};
                  w_sck_nxt   = 1'b0;
               end else if (r_bit_cnt == LAST_BIT) begin
                  w_state_nxt = DONE;
                  w_cs_n_nxt  = 1'b1;
                  w_frame_end = 1'b1;
               end else begin
                  w_bit_nxt = r_bit_cnt + 1'b1;
                  w_sck_nxt = 1'b1;
               end
            end
         end

         DONE: begin
            w_state_nxt = WAIT;
            w_wait_nxt  = WAIT_LOAD;
         end

         default: begin
            w_state_nxt = WAIT;
            w_cs_n_nxt  = 1'b1;
            w_sck_nxt   = 1'b0;
            w_wait_nxt  = WAIT_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= WAIT;
         r_half_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_wait_cnt  <= WAIT_LOAD;
         r_sck       <= 1'b0;
         r_cs_n      <= 1'b1;
         r_shift     <= '0;
         r_temp_word <= '0;
         r_valid     <= 1'b0;
         r_open_tc   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_half_cnt <= w_half_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_sck      <= w_sck_nxt;
         r_cs_n     <= w_cs_n_nxt;
         r_shift    <= w_shift_nxt;
         r_valid    <= w_frame_end;
         // Result registers load only on a finished frame, so a partial frame is never visible.
         if (w_frame_end) begin
            r_temp_word <= r_shift;
            r_open_tc   <= r_shift[OPEN_BIT];
            r_frame_err <= frame_fault(r_shift);
         end
      end
   end

   assign cs_n      = r_cs_n;
   assign sck       = r_sck;
   assign temp_word = r_temp_word;
   assign valid     = r_valid;
   assign open_tc   = r_open_tc;
   assign frame_err = r_frame_err;
   assign busy      = ~r_cs_n;

endmodule

// File: tb/tb_max6675_spi_reader.sv
// Self-checking bench for max6675_spi_reader with a behavioural MAX6675 driving SO.
// Frame contents, flag decoding and frame timing are all checked against bench-side expectations.
module tb_max6675_spi_reader;

   localparam int CLK_DIV     = 4;
   localparam int CONV_CYCLES = 100;
   localparam int BUSY_CYCLES = 33 * CLK_DIV;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b1;
   logic        so = 1'b0;
   logic        cs_n;
   logic        sck;
   logic [15:0] temp_word;
   logic        valid;
   logic        open_tc;
   logic        frame_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   max6675_spi_reader #(
      .CLK_DIV     (CLK_DIV),
      .CONV_CYCLES (CONV_CYCLES)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .so        (so),
      .cs_n      (cs_n),
      .sck       (sck),
      .temp_word (temp_word),
      .valid     (valid),
      .open_tc   (open_tc),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // Device model: D15 appears when cs_n falls, each sck fall presents the next lower bit.
   logic [15:0] model_word = 16'h0000;
   int          model_idx = 15;
   logic        model_active = 1'b0;

   always @(negedge cs_n or posedge cs_n or negedge sck) begin
      if (cs_n !== 1'b0) begin
         model_active = 1'b0;
         so = 1'b0;
      end else if (!model_active) begin
         model_active = 1'b1;
         model_idx = 15;
         so = model_word[15];
      end else if (model_idx > 0) begin
         model_idx = model_idx - 1;
         so = model_word[model_idx];
      end
   end

   // Reference decoding from the frame layout, using plain arithmetic on the word value.
   function automatic logic ref_open(input logic [15:0] w);
      return ((int'(w) / 4) % 2) == 1;
   endfunction

   function automatic logic ref_err(input logic [15:0] w);
      return (int'(w) >= 32768) || (((int'(w) / 2) % 2) == 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_cs_fall(input string name, input int exp_wait);
      int cyc;
      cyc = 0;
      while (cs_n !== 1'b0 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_wait_cycles"}, cyc, exp_wait);
   endtask

   // Called at the first negedge with cs_n low; returns one negedge after the valid cycle,
   // or right after releasing reset when reset_at is hit.
   task automatic frame_body(input string name, input logic [15:0] exp_temp,
                             input logic exp_open, input logic exp_err,
                             input int drop_en_at, input int reset_at);
      int          len;
      int          rises;
      int          first_rise;
      int          valid_seen;
      int          word_changes;
      logic        prev_sck;
      logic [15:0] held;
      len = 0;
      rises = 0;
      first_rise = -1;
      valid_seen = 0;
      word_changes = 0;
      held = temp_word;
      prev_sck = sck;
      while (cs_n === 1'b0 && len < 1000) begin
         if (sck && !prev_sck) begin
            rises++;
            if (first_rise < 0) first_rise = len;
            if (rises == drop_en_at) enable = 1'b0;
            if (rises == reset_at) begin
               reset_n = 1'b0;
               #1;
               check({name, "_rst_cs_n"}, cs_n, 1'b1);
               check({name, "_rst_sck"}, sck, 1'b0);
               check({name, "_rst_temp_word"}, temp_word, 16'h0000);
               check({name, "_rst_valid"}, valid, 1'b0);
               check({name, "_rst_open_tc"}, open_tc, 1'b0);
               check({name, "_rst_frame_err"}, frame_err, 1'b0);
               check({name, "_rst_busy"}, busy, 1'b0);
               repeat (3) @(negedge clk);
               reset_n = 1'b1;
               return;
            end
         end
         if (valid) valid_seen++;
         if (temp_word !== held) word_changes++;
         prev_sck = sck;
         len++;
         @(negedge clk);
      end
      check({name, "_busy_len"}, len, BUSY_CYCLES);
      check({name, "_sck_rises"}, rises, 16);
      check({name, "_first_rise"}, first_rise, CLK_DIV);
      check({name, "_no_early_valid"}, valid_seen, 0);
      check({name, "_no_partial_word"}, word_changes, 0);
      check({name, "_valid_at_cs_rise"}, valid, 1'b1);
      check({name, "_sck_low_at_cs_rise"}, sck, 1'b0);
      check({name, "_busy_low"}, busy, 1'b0);
      check({name, "_temp_word"}, temp_word, exp_temp);
      check({name, "_open_tc"}, open_tc, exp_open);
      check({name, "_frame_err"}, frame_err, exp_err);
      @(negedge clk);
      check({name, "_valid_one_cycle"}, valid, 1'b0);
      check({name, "_temp_word_held"}, temp_word, exp_temp);
   endtask

   typedef struct {
      string       name;
      logic [15:0] word;
      logic [15:0] exp_temp;
      logic        exp_open;
      logic        exp_err;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{"t200c",    16'h1900, 16'h1900, 1'b0, 1'b0};
      vecs[1] = '{"open",     16'h0004, 16'h0004, 1'b1, 1'b0};
      vecs[2] = '{"err_d15",  16'h8002, 16'h8002, 1'b0, 1'b1};
      vecs[3] = '{"err_clr",  16'h1900, 16'h1900, 1'b0, 1'b0};
      vecs[4] = '{"err_d1",   16'h0002, 16'h0002, 1'b0, 1'b1};
      vecs[5] = '{"err_dumm", 16'h8000, 16'h8000, 1'b0, 1'b1};
      vecs[6] = '{"max_temp", 16'h7FF8, 16'h7FF8, 1'b0, 1'b0};
      vecs[7] = '{"all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};

      // Reset state while held in reset
      reset_n = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_cs_n", cs_n, 1'b1);
      check("reset_sck", sck, 1'b0);
      check("reset_temp_word", temp_word, 16'h0000);
      check("reset_valid", valid, 1'b0);
      check("reset_open_tc", open_tc, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_busy", busy, 1'b0);
      reset_n = 1'b1;

      // Table-driven frames with enable held high; the first one also times the reset exit
      for (int i = 0; i < 8; i++) begin
         model_word = vecs[i].word;
         wait_cs_fall(vecs[i].name, CONV_CYCLES);
         frame_body(vecs[i].name, vecs[i].exp_temp, vecs[i].exp_open, vecs[i].exp_err, 0, 0);
      end

      // Reset asserted after the 7th sck rise discards the frame
      model_word = 16'h1234;
      wait_cs_fall("midrst", CONV_CYCLES);
      frame_body("midrst", 16'h1234, 1'b0, 1'b0, 0, 7);
      model_word = 16'h0ABC;
      wait_cs_fall("post_rst", CONV_CYCLES);
      frame_body("post_rst", 16'h0ABC, ref_open(16'h0ABC), ref_err(16'h0ABC), 0, 0);

      // Randomized frames checked against the reference decoding
      for (int i = 0; i < 6; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         model_word = w;
         wait_cs_fall("rand", CONV_CYCLES);
         frame_body("rand", w, ref_open(w), ref_err(w), 0, 0);
      end

      // Enable dropped mid-frame: frame completes, then no new frame starts
      model_word = 16'h0C85;
      wait_cs_fall("en_drop", CONV_CYCLES);
      frame_body("en_drop", 16'h0C85, ref_open(16'h0C85), ref_err(16'h0C85), 3, 0);
      begin
         int lows;
         int valids;
         lows = 0;
         valids = 0;
         repeat (300) begin
            @(negedge clk);
            if (cs_n !== 1'b1) lows++;
            if (valid !== 1'b0) valids++;
         end
         check("idle_no_cs_fall", lows, 0);
         check("idle_no_valid", valids, 0);
      end

      // Re-enable after the period has expired: cs_n falls on the next cycle
      model_word = 16'h3E20;
      enable = 1'b1;
      wait_cs_fall("re_en", 1);
      frame_body("re_en", 16'h3E20, ref_open(16'h3E20), ref_err(16'h3E20), 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
